// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the fetch/decode/write-back stages.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOV  = 4'h3;
  localparam logic [3:0] I_RMMOV  = 4'h4;
  localparam logic [3:0] I_MRMOV  = 4'h5;
  localparam logic [3:0] I_OP     = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSH   = 4'hA;
  localparam logic [3:0] I_POP    = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'b001;
  localparam logic [2:0] STAT_HLT = 3'b010;
  localparam logic [2:0] STAT_ADR = 3'b011;
  localparam logic [2:0] STAT_INS = 3'b100;

  localparam logic [3:0] RNONE    = 4'hF;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } d_reg_t;

  localparam d_reg_t NOP_BUBBLE = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    ifun:  4'h0,
    ra:    RNONE,
    rb:    RNONE,
    valc:  64'd0,
    valp:  64'd0
  };

  function automatic logic needs_regids(input logic [3:0] icode);
    unique case (icode)
      I_CMOV, I_IRMOV, I_RMMOV, I_MRMOV, I_OP, I_PUSH, I_POP: needs_regids = 1'b1;
      default:                                                needs_regids = 1'b0;
    endcase
  endfunction

  function automatic logic needs_valc(input logic [3:0] icode);
    unique case (icode)
      I_IRMOV, I_RMMOV, I_MRMOV, I_JXX, I_CALL: needs_valc = 1'b1;
      default:                                  needs_valc = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_align.sv
// Splits the 10 fetched bytes into instruction fields and computes the fall-through PC.
module fetch_align
  import y86_pkg::*;
(
  input  logic [79:0] imem_bytes,
  input  logic [63:0] f_pc,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        need_regids,
  output logic        need_valC
);

  always_comb begin
    icode       = imem_bytes[7:4];
    ifun        = imem_bytes[3:0];
    need_regids = needs_regids(icode);
    need_valC   = needs_valc(icode);

    rA = RNONE;
    rB = RNONE;
    if (need_regids) begin
      rA = imem_bytes[15:12];
      rB = imem_bytes[11:8];
    end

    // Constant is little-endian and starts right after the register byte, if any.
    valC = 64'd0;
    if (need_valC) begin
      valC = need_regids ? imem_bytes[79:16] : imem_bytes[71:8];
    end

    valP = f_pc + 64'd1 + {63'd0, need_regids} + (need_valC ? 64'd8 : 64'd0);
  end

endmodule

// File: rtl/fetch_dreg.sv
// Y86-64 fetch stage: PC selection, predicted-PC register and the D pipeline register.
module fetch_dreg
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] imem_addr,
  input  logic [79:0] imem_bytes,
  input  logic        imem_error,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  output logic [2:0]  f_stat,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP
);

  logic [63:0] pred_pc_q, pred_pc_d;
  logic [63:0] f_pc;
  logic [79:0] align_bytes;
  logic [3:0]  raw_icode;
  logic [3:0]  icode, ifun, ra, rb;
  logic [63:0] valc, valp;
  logic        need_regids, need_valc;
  logic        take_valc;
  d_reg_t      d_q, d_d;

  always_comb begin
    if (M_icode == I_JXX && !M_Cnd) begin
      f_pc = M_valA;
    end else if (W_icode == I_RET) begin
      f_pc = W_valM;
    end else begin
      f_pc = pred_pc_q;
    end
  end

  assign imem_addr = f_pc;
  assign raw_icode = imem_bytes[7:4];

  // A faulting fetch is decoded as a plain nop so downstream fields stay benign.
  assign align_bytes = imem_error ? {imem_bytes[79:8], I_NOP, 4'h0} : imem_bytes;

  fetch_align u_align (
    .imem_bytes  (align_bytes),
    .f_pc        (f_pc),
    .icode       (icode),
    .ifun        (ifun),
    .rA          (ra),
    .rB          (rb),
    .valC        (valc),
    .valP        (valp),
    .need_regids (need_regids),
    .need_valC   (need_valc)
  );

  always_comb begin
    if (imem_error) begin
      f_stat = STAT_ADR;
    end else if (raw_icode > I_POP) begin
      f_stat = STAT_INS;
    end else if (raw_icode == I_HALT) begin
      f_stat = STAT_HLT;
    end else begin
      f_stat = STAT_AOK;
    end
  end

  // jXX and call are the only valC-carrying forms without a register byte.
  assign take_valc = need_valc && !need_regids && (icode == I_JXX || icode == I_CALL);

  always_comb begin
    pred_pc_d = pred_pc_q;
    if (!F_stall) begin
      pred_pc_d = take_valc ? valc : valp;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pred_pc_q <= RESET_PC;
    end else begin
      pred_pc_q <= pred_pc_d;
    end
  end

  // Stall has priority over bubble when both are requested.
  always_comb begin
    d_d = d_q;
    if (!D_stall) begin
      if (D_bubble) begin
        d_d = NOP_BUBBLE;
      end else begin
        d_d.stat  = f_stat;
        d_d.icode = icode;
        d_d.ifun  = ifun;
        d_d.ra    = ra;
        d_d.rb    = rb;
        d_d.valc  = valc;
        d_d.valp  = valp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d_q <= NOP_BUBBLE;
    end else begin
      d_q <= d_d;
    end
  end

  assign D_stat  = d_q.stat;
  assign D_icode = d_q.icode;
  assign D_ifun  = d_q.ifun;
  assign D_rA    = d_q.ra;
  assign D_rB    = d_q.rb;
  assign D_valC  = d_q.valc;
  assign D_valP  = d_q.valp;

endmodule

// File: doc/fetch_dreg.md
Name: fetch_dreg

Overview:
- Y86-64 pipeline fetch stage plus the D pipeline register.
- Producer side of the decode/write-back interface: it drives D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC and D_valP into decode_wb.
- Holds the predicted-PC register, selects the fetch PC from misprediction and return feedback, splits instruction bytes, and applies stall/bubble control from pipeline control.

Parameters:
- RESET_PC, 64'd0, value loaded into the predicted-PC register on reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  synchronous, active-low reset
- imem_addr  out  64  fetch PC (f_pc), combinational
- imem_bytes  in  80  10 instruction bytes at imem_addr; byte k = bits [8k+7:8k]
- imem_error  in  1  address invalid
- M_icode  in  4  icode in the M stage
- M_Cnd  in  1  branch condition in the M stage
- M_valA  in  64  fall-through PC of a mispredicted jXX
- W_icode  in  4  icode in the W stage
- W_valM  in  64  return address popped by ret
- F_stall  in  1  hold the predicted-PC register
- D_stall  in  1  hold the D register
- D_bubble  in  1  load a nop into the D register
- f_stat  out  3  status of the instruction currently being fetched
- D_stat  out  3  D register stat
- D_icode  out  4  D register icode
- D_ifun  out  4  D register ifun
- D_rA  out  4  D register rA
- D_rB  out  4  D register rB
- D_valC  out  64  D register valC
- D_valP  out  64  D register valP

Behaviour:
- Encodings:
  - icode: HALT=0, NOP=1, CMOV=2, IRMOV=3, RMMOV=4, MRMOV=5, OP=6, JXX=7, CALL=8, RET=9, PUSH=A, POP=B.
  - stat: AOK=001, HLT=010, ADR=011, INS=100.
  - RNONE=4'hF.
- f_pc selection, combinational, in priority order:
  1. M_icode==JXX and !M_Cnd -> M_valA.
  2. Else W_icode==RET -> W_valM.
  3. Else predPC.
- Split:
  - icode=byte0[7:4], ifun=byte0[3:0].
  - If imem_error, icode and ifun are forced to NOP, 0 for the downstream fields.
- need_regids = icode in {CMOV, IRMOV, RMMOV, MRMOV, OP, PUSH, POP}.
  - rA=byte1[7:4] and rB=byte1[3:0] when need_regids, else RNONE for both.
- need_valC = icode in {IRMOV, RMMOV, MRMOV, JXX, CALL}.
  - valC = 8 little-endian bytes starting at byte2 when need_regids, else at byte1.
  - valC = 0 when not need_valC.
- Width arithmetic:
  - valP = f_pc + 1 + need_regids + 8*need_valC, computed modulo 2^64.
  - Wrap from FFFF_FFFF_FFFF_FFFF is legal and not an error.
- f_stat:
  - imem_error -> ADR.
  - Else icode > B -> INS.
  - Else icode==HALT -> HLT.
  - Else AOK.
- Predicted PC for the next fetch: valC for JXX or CALL, else valP.
- Predicted-PC register:
  - reset_n low -> RESET_PC.
  - Else F_stall -> hold.
  - Else load the predicted PC.
- D register update, in priority order:
  1. reset_n low -> bubble.
  2. Else D_stall -> hold all fields.
  3. Else D_bubble -> bubble.
  4. Else load {f_stat, icode, ifun, rA, rB, valC, valP}.
  - D_stall and D_bubble asserted together: stall wins.
- Bubble value: stat=AOK, icode=NOP, ifun=0, rA=rB=RNONE, valC=0, valP=0.
  - This is also the reset value of every D_* output.
- Reset timing:
  - Reset is synchronous; outputs change only at a clock edge where reset_n is low.
  - Reset asserted mid-stall overrides the stall.
- Latency:
  - Instruction bytes present at cycle n appear on D_* after the edge ending cycle n.
  - imem_addr and f_stat are valid in the same cycle.
- Halt handling:
  - Fetch does not halt itself. HLT, ADR and INS only propagate in stat.
  - Pipeline control freezes the pipeline via F_stall/D_bubble.

Decomposition:
- Shared package y86_pkg holds:
  - icode localparams and stat codes (STAT_AOK/HLT/ADR/INS);
  - RNONE;
  - NOP_BUBBLE field values.
- decode_wb uses the same package.
- One combinational sub-module, fetch_align: imem_bytes and f_pc in; icode, ifun, rA, rB, valC, valP, need_regids, need_valC out.
- The PC select, predPC register and D register remain in fetch_dreg.

Test Plan:
- Reset, then release; imem_bytes={30 F3 <64'd67 LE> ...} (irmovq $67,%rbx) -> imem_addr=0, and after the edge D_icode=3, D_rA=F, D_rB=3, D_valC=67, D_valP=10. Next imem_addr=10.
- At PC 10, bytes {70 <64'd100>} (jXX) -> D_valP=19, next imem_addr=100. Then M_icode=7, M_Cnd=0, M_valA=19 -> imem_addr=19 the same cycle.
- W_icode=9, W_valM=64'h40, no misprediction -> imem_addr=40h. With M_icode=7 and M_Cnd=0 also asserted -> M_valA wins.
- D_stall=1 for 2 cycles with new bytes -> D_* unchanged. D_bubble=1 -> D_icode=1, D_rA=D_rB=F, D_stat=001. D_stall and D_bubble both 1 -> hold.
- imem_error=1 -> f_stat=011 and D_stat=011. Byte0=C0 -> f_stat=100. Byte0=00 -> f_stat=010, D_valP=PC+1.
- Set predPC=FFFF_FFFF_FFFF_FFFF with byte0=10 (nop) -> D_valP=0. reset_n=0 during F_stall=1 -> next imem_addr=RESET_PC and D_* = bubble.
